// File: rtl/dk_motion_ctrl_pkg.sv
// Shared types and constants for the Donkey Kong motion controller.
// The state code is {motion class, facing_l}, so the class sits in bits [3:1].
package dk_motion_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE_R = 4'd0,
        IDLE_L = 4'd1,
        WALK_R = 4'd2,
        WALK_L = 4'd3,
        JUMP_R = 4'd4,
        JUMP_L = 4'd5,
        FALL_R = 4'd6,
        FALL_L = 4'd7
    } dk_motion_t;

    typedef enum logic [2:0] {
        CLS_IDLE = 3'd0,
        CLS_WALK = 3'd1,
        CLS_JUMP = 3'd2,
        CLS_FALL = 3'd3
    } dk_class_t;

    localparam logic [7:0] KEY_RIGHT   = 8'h74;
    localparam logic [7:0] KEY_LEFT    = 8'h6b;
    localparam logic [7:0] KEY_JUMP    = 8'h29;
    localparam logic [3:0] GROUND_FLAG = 4'd1;

    function automatic dk_motion_t mk_motion(input dk_class_t c, input logic facing_l);
        return dk_motion_t'({c, facing_l});
    endfunction

    function automatic dk_class_t motion_class(input dk_motion_t m);
        return dk_class_t'({1'b0, m[3:1]});
    endfunction

endpackage

// File: rtl/dk_motion_ctrl_if.sv
// Loop between the motion controller and the combinational position mapper.
// master = mapper/keyboard side, slave = the controller.
interface dk_motion_ctrl_if;
    logic [7:0]  keycode;
    logic        press;
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  no;
    logic [24:0] counter;
    logic [15:0] prev_x;
    logic [15:0] prev_y;
    logic [3:0]  dk_motion;
    logic [18:0] num;
    logic        facing_l;

    modport master (
        output keycode, press, x, y, no,
        input  counter, prev_x, prev_y, dk_motion, num, facing_l
    );

    modport slave (
        input  keycode, press, x, y, no,
        output counter, prev_x, prev_y, dk_motion, num, facing_l
    );
endinterface

// File: rtl/dk_motion_ctrl_tick_gen.sv
// Frame-tick counter: counts 0..TICK_MAX inclusive and wraps; tick is high
// for the single cycle spent at TICK_MAX.
module dk_tick_gen #(
    parameter logic [24:0] TICK_MAX = 25'd4500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [24:0] o_counter,
    output logic        o_tick
);

    logic [24:0] r_counter;
    logic        w_at_max;

    assign w_at_max = (r_counter == TICK_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_counter <= '0;
        else if (w_at_max)
            r_counter <= '0;
        else
            r_counter <= r_counter + 25'd1;
    end

    assign o_counter = r_counter;
    assign o_tick    = w_at_max;

endmodule

// File: rtl/dk_motion_ctrl.sv
// Donkey Kong motion controller: tick generator, registered position and motion FSM.
// Define DK_VAR_JUMP_EN to let an early jump-key release cut the rise short.
module dk_motion_ctrl
    import dk_motion_ctrl_pkg::*;
#(
    parameter logic [24:0] TICK_MAX    = 25'd4500000,
    parameter logic [18:0] JUMP_TICKS  = 19'd10,
    parameter logic [18:0] MIN_JUMP    = 19'd3,
    parameter logic [18:0] WALK_FRAMES = 19'd4,
    parameter logic [15:0] START_X     = 16'd0,
    parameter logic [15:0] START_Y     = 16'd0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    dk_motion_ctrl_if.slave  bus
);

`ifdef DK_VAR_JUMP_EN
    localparam bit VAR_JUMP = 1'b1;
`else
    localparam bit VAR_JUMP = 1'b0;
`endif

    logic [24:0] w_counter;
    logic        w_tick;

    dk_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick_gen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .o_counter (w_counter),
        .o_tick    (w_tick)
    );

    logic [15:0] r_prev_x;
    logic [15:0] r_prev_y;
    dk_motion_t  r_motion;
    logic [18:0] r_num;
    logic        r_facing;

    logic        w_left, w_right, w_jump, w_jump_rel, w_ground;
    logic        w_facing_nxt, w_var_cut, w_rise_done;
    logic [18:0] w_num_inc, w_walk_nxt, w_fall_nxt;
    dk_class_t   w_cls;

    // Key decode: keycode only counts while press is high (release is its own event).
    assign w_left     = bus.press && (bus.keycode == KEY_LEFT);
    assign w_right    = bus.press && (bus.keycode == KEY_RIGHT);
    assign w_jump     = bus.press && (bus.keycode == KEY_JUMP);
    assign w_jump_rel = !bus.press && (bus.keycode == KEY_JUMP);
    assign w_ground   = (bus.no == GROUND_FLAG);

    assign w_facing_nxt = w_left ? 1'b1 : (w_right ? 1'b0 : r_facing);
    assign w_cls        = motion_class(r_motion);

    assign w_num_inc   = r_num + 19'd1;
    assign w_walk_nxt  = (w_num_inc >= WALK_FRAMES) ? 19'd0 : w_num_inc;
    assign w_fall_nxt  = (r_num == 19'h7FFFF) ? r_num : w_num_inc;
    assign w_rise_done = (w_num_inc == JUMP_TICKS);
    assign w_var_cut   = VAR_JUMP && w_jump_rel && (r_num >= MIN_JUMP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_x <= START_X;
            r_prev_y <= START_Y;
            r_motion <= FALL_R;
            r_num    <= '0;
            r_facing <= 1'b0;
        end else if (w_tick) begin
            r_prev_x <= bus.x;
            r_prev_y <= bus.y;
            r_facing <= w_facing_nxt;
            case (w_cls)
                CLS_IDLE, CLS_WALK: begin
                    if (!w_ground) begin
                        r_motion <= mk_motion(CLS_FALL, w_facing_nxt);
                        r_num    <= '0;
                    end else if (w_jump) begin
                        r_motion <= mk_motion(CLS_JUMP, w_facing_nxt);
                        r_num    <= '0;
                    end else if (w_left || w_right) begin
                        // Walk frame index only advances if we were already walking.
                        r_motion <= mk_motion(CLS_WALK, w_facing_nxt);
                        r_num    <= (w_cls == CLS_WALK) ? w_walk_nxt : 19'd0;
                    end else begin
                        r_motion <= mk_motion(CLS_IDLE, w_facing_nxt);
                        r_num    <= '0;
                    end
                end
                CLS_JUMP: begin
                    // Ground flag is ignored mid-rise; only the tick budget (or a cut) ends it.
                    if (w_rise_done || w_var_cut) begin
                        r_motion <= mk_motion(CLS_FALL, w_facing_nxt);
                        r_num    <= '0;
                    end else begin
                        r_motion <= mk_motion(CLS_JUMP, w_facing_nxt);
                        r_num    <= w_num_inc;
                    end
                end
                CLS_FALL: begin
                    if (w_ground) begin
                        r_motion <= mk_motion((w_left || w_right) ? CLS_WALK : CLS_IDLE,
                                              w_facing_nxt);
                        r_num    <= '0;
                    end else begin
                        r_motion <= mk_motion(CLS_FALL, w_facing_nxt);
                        r_num    <= w_fall_nxt;
                    end
                end
                default: begin
                    r_motion <= mk_motion(CLS_FALL, w_facing_nxt);
                    r_num    <= '0;
                end
            endcase
        end
    end

    assign bus.counter   = w_counter;
    assign bus.prev_x    = r_prev_x;
    assign bus.prev_y    = r_prev_y;
    assign bus.dk_motion = r_motion;
    assign bus.num       = r_num;
    assign bus.facing_l  = r_facing;

endmodule

// File: tb/tb_dk_motion_ctrl.sv
// Directed bench for dk_motion_ctrl with a 10-cycle frame (TICK_MAX = 9).
// Expectations for the jump-release case follow DK_VAR_JUMP_EN.
module tb_dk_motion_ctrl;
    import dk_motion_ctrl_pkg::*;

    localparam logic [24:0] TMAX = 25'd9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dk_motion_ctrl_if bus();

    dk_motion_ctrl #(.TICK_MAX(TMAX)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0]  key;
        logic        press;
        logic [3:0]  no;
        logic [3:0]  m;
        logic [18:0] n;
        logic        f;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [7:0] k, input logic p, input logic [3:0] no,
                                input logic [3:0] m, input logic [18:0] n, input logic f);
        vec_t v;
        v.key = k; v.press = p; v.no = no; v.m = m; v.n = n; v.f = f;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive inputs, wait for the frame tick, sample #1 after the tick edge.
    task automatic do_tick(input logic [7:0] k, input logic p, input logic [3:0] no,
                           input logic [15:0] x, input logic [15:0] y);
        int w;
        bus.keycode = k; bus.press = p; bus.no = no; bus.x = x; bus.y = y;
        w = 0;
        while (bus.counter != TMAX && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (w >= 30) begin
            n_chk++; n_fail++;
            $display("FAIL tick_timeout: counter stuck at %0d, expected %0d", bus.counter, TMAX);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] x, y;
        bus.keycode = 8'h00; bus.press = 1'b0; bus.no = 4'd0; bus.x = 16'd0; bus.y = 16'd0;

        // Reset values, then reset reasserted mid-count.
        repeat (2) @(negedge clk);
        check("reset motion", 32'(bus.dk_motion), 32'(FALL_R));
        check("reset num", 32'(bus.num), 32'd0);
        check("reset facing", 32'(bus.facing_l), 32'd0);
        check("reset prevX", 32'(bus.prev_x), 32'd0);
        check("reset prevY", 32'(bus.prev_y), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("count before reset", 32'(bus.counter), 32'd4);
        rst_n = 1'b0;
        #1;
        check("async reset counter", 32'(bus.counter), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("counter seq %0d", i), 32'(bus.counter), 32'(i % 10));
            @(negedge clk);
        end

        // Directed tick-by-tick vectors.
        add(8'h00, 0, 1, IDLE_R, 0, 0);
        add(8'h74, 1, 1, WALK_R, 0, 0);
        add(8'h74, 1, 1, WALK_R, 1, 0);
        add(8'h74, 1, 1, WALK_R, 2, 0);
        add(8'h74, 1, 1, WALK_R, 3, 0);
        add(8'h74, 1, 1, WALK_R, 0, 0);
        add(8'h74, 0, 1, IDLE_R, 0, 0);
        add(8'h29, 1, 1, JUMP_R, 0, 0);
        for (int i = 1; i <= 9; i++) add(8'h29, 1, 0, JUMP_R, 19'(i), 0);
        add(8'h29, 1, 0, FALL_R, 0, 0);
        add(8'h29, 1, 0, FALL_R, 1, 0);
        add(8'h00, 0, 1, IDLE_R, 0, 0);
        add(8'h6b, 1, 1, WALK_L, 0, 1);
        add(8'h6b, 1, 1, WALK_L, 1, 1);
        add(8'h6b, 1, 0, FALL_L, 0, 1);
        add(8'h29, 1, 0, FALL_L, 1, 1);
        add(8'h00, 0, 0, FALL_L, 2, 1);
        add(8'h6b, 1, 1, WALK_L, 0, 1);
        add(8'h00, 0, 1, IDLE_L, 0, 1);
        add(8'h74, 1, 1, WALK_R, 0, 0);
        add(8'h29, 1, 1, JUMP_R, 0, 0);
        add(8'h29, 1, 1, JUMP_R, 1, 0);
        add(8'h6b, 1, 1, JUMP_L, 2, 1);
        add(8'h29, 0, 1, JUMP_L, 3, 1);
`ifdef DK_VAR_JUMP_EN
        add(8'h29, 0, 1, FALL_L, 0, 1);
`else
        for (int i = 4; i <= 9; i++) add(8'h29, 0, 1, JUMP_L, 19'(i), 1);
        add(8'h29, 0, 1, FALL_L, 0, 1);
`endif
        add(8'h00, 0, 1, IDLE_L, 0, 1);

        foreach (vecs[i]) begin
            x = 16'(i + 4);
            y = 16'(300 - i);
            do_tick(vecs[i].key, vecs[i].press, vecs[i].no, x, y);
            check($sformatf("v%0d motion", i), 32'(bus.dk_motion), 32'(vecs[i].m));
            check($sformatf("v%0d num", i), 32'(bus.num), 32'(vecs[i].n));
            check($sformatf("v%0d facing", i), 32'(bus.facing_l), 32'(vecs[i].f));
            check($sformatf("v%0d prevX", i), 32'(bus.prev_x), 32'(x));
            check($sformatf("v%0d prevY", i), 32'(bus.prev_y), 32'(y));
            check($sformatf("v%0d counter wrap", i), 32'(bus.counter), 32'd0);
            // Mid-frame: new mapper values must not leak into the registers.
            @(negedge clk);
            bus.x = 16'hBEEF; bus.y = 16'hBEEF; bus.no = ~vecs[i].no;
            repeat (3) @(negedge clk);
            check($sformatf("v%0d hold prevX", i), 32'(bus.prev_x), 32'(x));
            check($sformatf("v%0d hold motion", i), 32'(bus.dk_motion), 32'(vecs[i].m));
        end

        // Reset in the middle of a jump: nothing of the jump survives.
        do_tick(8'h29, 1, 1, 16'd50, 16'd60);
        check("prejump motion", 32'(bus.dk_motion), 32'(JUMP_L));
        do_tick(8'h29, 1, 1, 16'd51, 16'd61);
        check("prejump num", 32'(bus.num), 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midjump reset motion", 32'(bus.dk_motion), 32'(FALL_R));
        check("midjump reset num", 32'(bus.num), 32'd0);
        check("midjump reset facing", 32'(bus.facing_l), 32'd0);
        check("midjump reset prevX", 32'(bus.prev_x), 32'd0);
        check("midjump reset prevY", 32'(bus.prev_y), 32'd0);
        check("midjump reset counter", 32'(bus.counter), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_tick(8'h29, 0, 1, 16'd7, 16'd8);
        check("post reset land", 32'(bus.dk_motion), 32'(IDLE_R));
        check("post reset prevX", 32'(bus.prev_x), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
